matrix_stream_mac3: RTL and testbench

//  Sequential 3x3 matrix multiplier C = A*B with stream interfaces.

---
 rtl/matrix_stream_mac3.sv | 161 ++++++++++++++++
 tb/tb_matrix_stream_mac3.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_mac3.sv
// Stream-fed 3x3 matrix multiplier C = A*B that reuses one MAC for all products.
// Define MATMUL_SIGNED_EN for two's-complement operands; the default build is unsigned.
`timescale 1ns/1ps
module matrix_stream_mac3 #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] ops_r [18];
  logic [4:0]        idx_r;
  logic [1:0]        i_r;
  logic [1:0]        j_r;
  logic [1:0]        k_r;
  logic [OUT_W-1:0]  acc_r;
  logic [OUT_W-1:0]  c_r [9];
  logic [3:0]        oidx_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic [OUT_W-1:0]  out_data_r;
  logic              busy_r;

  logic [3:0]        a_idx_s;
  logic [3:0]        b_idx_s;
  logic [3:0]        c_idx_s;
  logic [DATA_W-1:0] a_s;
  logic [DATA_W-1:0] b_s;
  logic [OUT_W-1:0]  a_ext_s;
  logic [OUT_W-1:0]  b_ext_s;
  logic [OUT_W-1:0]  prod_s;
  logic [OUT_W-1:0]  acc_next_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;

  // Operand select and MAC datapath for the current (i,j,k) step.
  always_comb begin
    a_idx_s = ({2'b00, i_r} * 4'd3) + {2'b00, k_r};
    b_idx_s = ({2'b00, k_r} * 4'd3) + {2'b00, j_r};
    c_idx_s = ({2'b00, i_r} * 4'd3) + {2'b00, j_r};
    a_s     = ops_r[{1'b0, a_idx_s}];
    b_s     = ops_r[5'd9 + {1'b0, b_idx_s}];
    // Extending to OUT_W before multiplying keeps the low OUT_W product bits exact in both builds.
`ifdef MATMUL_SIGNED_EN
    a_ext_s = {{(OUT_W-DATA_W){a_s[DATA_W-1]}}, a_s};
    b_ext_s = {{(OUT_W-DATA_W){b_s[DATA_W-1]}}, b_s};
`else
    a_ext_s = {{(OUT_W-DATA_W){1'b0}}, a_s};
    b_ext_s = {{(OUT_W-DATA_W){1'b0}}, b_s};
`endif
    prod_s     = a_ext_s * b_ext_s;
    acc_next_s = ((k_r == 2'd0) ? {OUT_W{1'b0}} : acc_r) + prod_s;
  end

  // Load / compute / output sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD;
      idx_r       <= 5'd0;
      i_r         <= 2'd0;
      j_r         <= 2'd0;
      k_r         <= 2'd0;
      acc_r       <= {OUT_W{1'b0}};
      oidx_r      <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      busy_r      <= 1'b0;
      for (int n = 0; n < 18; n++) ops_r[n] <= {DATA_W{1'b0}};
      for (int n = 0; n < 9; n++) c_r[n] <= {OUT_W{1'b0}};
    end else begin
      case (state_r)
        LOAD: begin
          if (in_valid) begin
            ops_r[idx_r] <= in_data;
            if (idx_r == 5'd17) begin
              idx_r      <= 5'd0;
              state_r    <= COMPUTE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
            end else begin
              idx_r <= idx_r + 5'd1;
            end
          end
        end
        COMPUTE: begin
          acc_r <= acc_next_s;
          if (k_r == 2'd2) begin
            c_r[c_idx_s] <= acc_next_s;
            k_r          <= 2'd0;
            if (j_r == 2'd2) begin
              j_r <= 2'd0;
              if (i_r == 2'd2) begin
                // c1 was finished long before the final MAC, so it can be presented now.
                i_r         <= 2'd0;
                state_r     <= OUTPUT;
                out_valid_r <= 1'b1;
                out_data_r  <= c_r[0];
                out_last_r  <= 1'b0;
                oidx_r      <= 4'd0;
              end else begin
                i_r <= i_r + 2'd1;
              end
            end else begin
              j_r <= j_r + 2'd1;
            end
          end else begin
            k_r <= k_r + 2'd1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (oidx_r == 4'd8) begin
              state_r     <= LOAD;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
              oidx_r      <= 4'd0;
            end else begin
              oidx_r     <= oidx_r + 4'd1;
              out_data_r <= c_r[oidx_r + 4'd1];
              out_last_r <= (oidx_r == 4'd7);
            end
          end
        end
        default: begin
          state_r     <= LOAD;
          idx_r       <= 5'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_mac3.sv
// Scoreboard bench for matrix_stream_mac3 against a plain-arithmetic matrix product model.
`timescale 1ns/1ps
module tb_matrix_stream_mac3;

  typedef logic [7:0] ops_t [18];
  typedef struct {
    logic [18:0] d;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [18:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        busy;

  matrix_stream_mac3 #(.DATA_W(8), .OUT_W(19)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int b9_cycle = -1;
  int rdy_mode = 1;
  int stall_cnt = 0;
  exp_t exp_q[$];
  logic [18:0] got_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int sval(input logic [7:0] x);
`ifdef MATMUL_SIGNED_EN
    return x[7] ? int'(x) - 256 : int'(x);
`else
    return int'(x);
`endif
  endfunction

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], truncated to the 19-bit result width.
  task automatic push_model(input ops_t ops);
    exp_t e;
    int s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += sval(ops[i*3+k]) * sval(ops[9+k*3+j]);
        e.d = 19'(s);
        e.last = (i == 2) && (j == 2);
        exp_q.push_back(e);
      end
  endtask

  task automatic send(input ops_t ops, input int nbeats, input int gap);
    int t;
    for (int n = 0; n < nbeats; n++) begin
      @(negedge clk);
      while ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = ops[n];
      t = 0;
      while (!in_ready && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
      if (n == 17) b9_cycle = cycle + 1;
    end
    if (nbeats == 18) begin
      push_model(ops);
      // Junk held on the input during COMPUTE must be ignored.
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Downstream ready: random, always, or 5 stall cycles before each beat.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'($urandom_range(1));
      2: begin
        if (!out_valid) begin
          out_ready = 1'b0;
          stall_cnt = 0;
        end else if (stall_cnt < 5) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
          stall_cnt = 0;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: scoreboard pop, hold stability, first-beat latency, no input while busy.
  initial begin
    logic prev_valid = 1'b0;
    logic hold_pend = 1'b0;
    logic [18:0] hold_d = 19'd0;
    logic hold_l = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_pend) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(hold_d));
          check("hold_last", 32'(out_last), 32'(hold_l));
        end
        hold_pend = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
        if (out_valid && !prev_valid) check("latency", 32'(cycle - b9_cycle), 32'd27);
        prev_valid = out_valid;
        if (busy) check("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(out_data), 32'h7fffffff);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.d));
            check("out_last", 32'(out_last), 32'(e.last));
            got_q.push_back(out_data);
          end
        end
      end else begin
        prev_valid = 1'b0;
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ops_t ops;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;

    // Mixed-value unsigned example.
    ops = '{8'hFF, 8'h10, 8'hB5, 8'hA1, 8'hA1, 8'h11, 8'h0C, 8'h00, 8'h12,
            8'h11, 8'h1D, 8'hD1, 8'hFF, 8'hEE, 8'h61, 8'h21, 8'h18, 8'h13};
    got_q.delete(); rdy_mode = 1;
    send(ops, 18, 0); wait_drain();
    check("t2_count", 32'(got_q.size()), 32'd9);
`ifndef MATMUL_SIGNED_EN
    if (got_q.size() > 0) check("t2_c1", 32'(got_q[0]), 32'h03834);
`endif

    // Identity times 1..9 with stalled downstream.
    for (int n = 0; n < 9; n++) ops[n] = (n % 4 == 0) ? 8'd1 : 8'd0;
    for (int n = 0; n < 9; n++) ops[9+n] = 8'(n + 1);
    got_q.delete(); rdy_mode = 2;
    send(ops, 18, 20); wait_drain();
    check("t3_count", 32'(got_q.size()), 32'd9);
    for (int n = 0; n < got_q.size(); n++) check("t3_value", 32'(got_q[n]), 32'(n + 1));

    // All-ones bytes.
    for (int n = 0; n < 18; n++) ops[n] = 8'hFF;
    got_q.delete(); rdy_mode = 1;
    send(ops, 18, 0); wait_drain();
    check("t4_count", 32'(got_q.size()), 32'd9);
`ifndef MATMUL_SIGNED_EN
    for (int n = 0; n < got_q.size(); n++) check("t4_value", 32'(got_q[n]), 32'h2FA03);
`endif

    // Reset in the middle of an operand stream.
    for (int n = 0; n < 18; n++) ops[n] = 8'($urandom);
    send(ops, 10, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 9; n++) ops[n] = (n % 4 == 0) ? 8'd1 : 8'd0;
    for (int n = 0; n < 9; n++) ops[9+n] = (n % 4 == 0) ? 8'd2 : 8'd0;
    got_q.delete();
    send(ops, 18, 10); wait_drain();
    check("t5_count", 32'(got_q.size()), 32'd9);
    for (int n = 0; n < got_q.size(); n++)
      check("t5_value", 32'(got_q[n]), (n % 4 == 0) ? 32'd2 : 32'd0);

`ifdef MATMUL_SIGNED_EN
    for (int n = 0; n < 18; n++) ops[n] = (n < 9) ? 8'h80 : 8'h7F;
    got_q.delete();
    send(ops, 18, 0); wait_drain();
    check("t6a_count", 32'(got_q.size()), 32'd9);
    for (int n = 0; n < got_q.size(); n++) check("t6a_value", 32'(got_q[n]), 32'h74180);
    for (int n = 0; n < 18; n++) ops[n] = 8'h80;
    got_q.delete();
    send(ops, 18, 0); wait_drain();
    check("t6b_count", 32'(got_q.size()), 32'd9);
    for (int n = 0; n < got_q.size(); n++) check("t6b_value", 32'(got_q[n]), 32'h0C000);
`endif

    // Random operands, random input gaps and random downstream ready.
    rdy_mode = 0;
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 18; n++) ops[n] = 8'($urandom);
      send(ops, 18, 30);
      wait_drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
